// File: rtl/fdc_pkg.sv
// Shared definitions for the FDC command-phase responder: opcodes, state
// encoding, MSR bit positions and the per-opcode byte-count tables.
package fdc_pkg;

    localparam logic [4:0] OP_READ      = 5'h06;
    localparam logic [4:0] OP_WRITE     = 5'h05;
    localparam logic [4:0] OP_RECAL     = 5'h07;
    localparam logic [4:0] OP_SEEK      = 5'h0F;
    localparam logic [4:0] OP_SENSE_INT = 5'h08;
    localparam logic [4:0] OP_SPECIFY   = 5'h03;
    localparam logic [4:0] OP_SENSE_DRV = 5'h04;

    localparam logic [7:0] INVALID_ST0 = 8'h80;

    localparam int MSR_RQM  = 7;
    localparam int MSR_DIO  = 6;
    localparam int MSR_NDMA = 5;
    localparam int MSR_CB   = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CMD    = 2'd1,
        ST_EXEC   = 2'd2,
        ST_RESULT = 2'd3
    } fdc_state_t;

    // Command length in bytes, opcode included
    function automatic logic [3:0] cmd_len(input logic [4:0] op);
        case (op)
            OP_READ, OP_WRITE:        cmd_len = 4'd9;
            OP_RECAL, OP_SENSE_DRV:   cmd_len = 4'd2;
            OP_SEEK, OP_SPECIFY:      cmd_len = 4'd3;
            default:                  cmd_len = 4'd1;
        endcase
    endfunction

    // Number of result bytes returned to the CPU
    function automatic logic [2:0] res_len(input logic [4:0] op);
        case (op)
            OP_READ, OP_WRITE:        res_len = 3'd7;
            OP_SENSE_INT:             res_len = 3'd2;
            OP_SENSE_DRV:             res_len = 3'd1;
            OP_RECAL, OP_SEEK,
            OP_SPECIFY:               res_len = 3'd0;
            default:                  res_len = 3'd1;
        endcase
    endfunction

    function automatic logic op_valid(input logic [4:0] op);
        case (op)
            OP_READ, OP_WRITE, OP_RECAL, OP_SEEK,
            OP_SENSE_INT, OP_SPECIFY, OP_SENSE_DRV: op_valid = 1'b1;
            default:                                op_valid = 1'b0;
        endcase
    endfunction

    // Commands whose completion raises the interrupt line
    function automatic logic op_irq(input logic [4:0] op);
        case (op)
            OP_READ, OP_WRITE, OP_SEEK, OP_RECAL: op_irq = 1'b1;
            default:                              op_irq = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/fdc_cmd_phase_io_decode.sv
// ISA I/O decode: address match for MSR/data register, AEN gating and
// strobe edge detection producing single-cycle write/read-advance pulses.
module fdc_cmd_phase_io_decode
    import fdc_pkg::*;
#(
    parameter logic [9:0] BASE_ADDR = 10'h3F0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] i_addr,
    input  logic       i_aen,
    input  logic       i_ior_n,
    input  logic       i_iow_n,
    output logic       o_hit_msr,
    output logic       o_hit_data,
    output logic       o_dout_en,
    output logic       o_wr_acc,
    output logic       o_rd_adv
);

    logic r_ior_q;
    logic r_iow_q;
    logic r_rd_data_hit;

    assign o_hit_msr  = (i_addr == BASE_ADDR + 10'd4);
    assign o_hit_data = (i_addr == BASE_ADDR + 10'd5);
    assign o_dout_en  = ~i_ior_n & ~i_aen & (o_hit_msr | o_hit_data);

    // Falling edge of iow_n on the data register accepts exactly one byte
    assign o_wr_acc = r_iow_q & ~i_iow_n & ~i_aen & o_hit_data;

    // Rising edge of ior_n after a data-register read advances the pointer
    assign o_rd_adv = ~r_ior_q & i_ior_n & r_rd_data_hit;

    // Strobe history and the address latched during a read strobe
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ior_q       <= 1'b1;
            r_iow_q       <= 1'b1;
            r_rd_data_hit <= 1'b0;
        end else begin
            r_ior_q <= i_ior_n;
            r_iow_q <= i_iow_n;
            if (!i_ior_n) begin
                r_rd_data_hit <= o_hit_data & ~i_aen;
            end
        end
    end

endmodule

// File: rtl/fdc_cmd_phase.sv
// uPD765-style command/execution/result phase sequencer seen by the host
// through the MSR (BASE+4) and data register (BASE+5).
module fdc_cmd_phase
    import fdc_pkg::*;
#(
    parameter logic [9:0] BASE_ADDR = 10'h3F0,
    parameter int         NRES_MAX  = 7
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [19:0] a,
    input  logic        aen,
    input  logic        ior_n,
    input  logic        iow_n,
    input  logic [7:0]  din,
    output logic [7:0]  dout,
    output logic        dout_en,
    output logic        exec_start,
    output logic [4:0]  cmd_op,
    output logic [2:0]  cmd_flags,
    output logic [63:0] cmd_params,
    input  logic        exec_done,
    input  logic [55:0] res_bytes,
    output logic        irq6
);

    fdc_state_t  r_state;
    fdc_state_t  w_state_nxt;
    logic [3:0]  r_pcnt;
    logic [4:0]  r_op;
    logic [2:0]  r_flags;
    logic [63:0] r_params;
    logic [55:0] r_res;
    logic [2:0]  r_ptr;
    logic [2:0]  r_nres;
    logic        r_exec_start;
    logic        r_irq;

    logic        w_hit_msr;
    logic        w_hit_data;
    logic        w_wr_acc;
    logic        w_rd_adv;
    logic [3:0]  w_pcnt_inc;
    logic [2:0]  w_nres_new;
    logic [7:0]  w_msr;
    logic [63:0] w_res_wide;
    logic        w_irq_set;
    logic        w_irq_clr;
    logic        w_unused_addr;

    assign w_unused_addr = ^a[19:10];

    fdc_cmd_phase_io_decode #(
        .BASE_ADDR (BASE_ADDR)
    ) u_io_decode (
        .clk        (clk),
        .rst        (rst),
        .i_addr     (a[9:0]),
        .i_aen      (aen),
        .i_ior_n    (ior_n),
        .i_iow_n    (iow_n),
        .o_hit_msr  (w_hit_msr),
        .o_hit_data (w_hit_data),
        .o_dout_en  (dout_en),
        .o_wr_acc   (w_wr_acc),
        .o_rd_adv   (w_rd_adv)
    );

    assign w_pcnt_inc = (r_pcnt == 4'd8) ? 4'd8 : r_pcnt + 4'd1;
    assign w_nres_new = (res_len(r_op) > 3'(NRES_MAX)) ? 3'(NRES_MAX) : res_len(r_op);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode from host strobes and engine completion
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_wr_acc) begin
                    if (!op_valid(din[4:0])) begin
                        w_state_nxt = ST_RESULT;
                    end else if (cmd_len(din[4:0]) == 4'd1) begin
                        w_state_nxt = ST_EXEC;
                    end else begin
                        w_state_nxt = ST_CMD;
                    end
                end
            end
            ST_CMD: begin
                if (w_wr_acc && (w_pcnt_inc == cmd_len(r_op) - 4'd1)) begin
                    w_state_nxt = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (exec_done) begin
                    w_state_nxt = (w_nres_new == 3'd0) ? ST_IDLE : ST_RESULT;
                end
            end
            ST_RESULT: begin
                if (w_rd_adv && (r_ptr == r_nres - 3'd1)) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign w_irq_set = (r_state == ST_EXEC) && exec_done && op_irq(r_op);
    assign w_irq_clr = ((r_state == ST_IDLE) && w_wr_acc && (din[4:0] == OP_SENSE_INT)) ||
                       ((r_state == ST_RESULT) && w_rd_adv && (r_ptr == 3'd0));

    // Command capture, result latching, pointer, exec pulse and interrupt
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pcnt       <= 4'd0;
            r_op         <= 5'd0;
            r_flags      <= 3'd0;
            r_params     <= 64'd0;
            r_res        <= 56'd0;
            r_ptr        <= 3'd0;
            r_nres       <= 3'd0;
            r_exec_start <= 1'b0;
            r_irq        <= 1'b0;
        end else begin
            r_exec_start <= (w_state_nxt == ST_EXEC) && (r_state != ST_EXEC);
            if (w_irq_set) begin
                r_irq <= 1'b1;
            end else if (w_irq_clr) begin
                r_irq <= 1'b0;
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_wr_acc) begin
                        r_op     <= din[4:0];
                        r_flags  <= din[7:5];
                        r_params <= 64'd0;
                        r_pcnt   <= 4'd0;
                        if (!op_valid(din[4:0])) begin
                            r_res  <= {48'd0, INVALID_ST0};
                            r_ptr  <= 3'd0;
                            r_nres <= 3'd1;
                        end
                    end
                end
                ST_CMD: begin
                    if (w_wr_acc) begin
                        r_params[{r_pcnt[2:0], 3'b000} +: 8] <= din;
                        r_pcnt <= w_pcnt_inc;
                    end
                end
                ST_EXEC: begin
                    if (exec_done) begin
                        r_res  <= res_bytes;
                        r_ptr  <= 3'd0;
                        r_nres <= w_nres_new;
                    end
                end
                ST_RESULT: begin
                    if (w_rd_adv) begin
                        r_ptr <= (r_ptr == r_nres - 3'd1) ? 3'd0 : r_ptr + 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Main status register per phase
    always_comb begin
        w_msr = 8'h00;
        case (r_state)
            ST_IDLE:   w_msr[MSR_RQM] = 1'b1;
            ST_CMD: begin
                w_msr[MSR_RQM] = 1'b1;
                w_msr[MSR_CB]  = 1'b1;
            end
            ST_EXEC:   w_msr[MSR_CB] = 1'b1;
            ST_RESULT: begin
                w_msr[MSR_RQM] = 1'b1;
                w_msr[MSR_DIO] = 1'b1;
                w_msr[MSR_CB]  = 1'b1;
            end
            default:   w_msr = 8'h00;
        endcase
        w_msr[MSR_NDMA] = 1'b0;
    end

    assign w_res_wide = {8'hFF, r_res};

    // Read data mux: MSR, current result byte, or idle bus value
    always_comb begin
        dout = 8'hFF;
        if (w_hit_msr) begin
            dout = w_msr;
        end else if (w_hit_data && (r_state == ST_RESULT)) begin
            dout = w_res_wide[{r_ptr, 3'b000} +: 8];
        end
    end

    assign exec_start = r_exec_start;
    assign cmd_op     = r_op;
    assign cmd_flags  = r_flags;
    assign cmd_params = r_params;
    assign irq6       = r_irq;

endmodule

// File: tb/tb_fdc_cmd_phase.sv
// Bench for fdc_cmd_phase: host-side register reads/writes with an
// expected-command queue checked when exec_start fires and an
// expected-read queue checked when each read sample is taken.
module tb_fdc_cmd_phase;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [19:0] a = 20'h0;
    logic        aen = 1'b0;
    logic        ior_n = 1'b1;
    logic        iow_n = 1'b1;
    logic [7:0]  din = 8'h0;
    logic [7:0]  dout;
    logic        dout_en;
    logic        exec_start;
    logic [4:0]  cmd_op;
    logic [2:0]  cmd_flags;
    logic [63:0] cmd_params;
    logic        exec_done = 1'b0;
    logic [55:0] res_bytes = 56'h0;
    logic        irq6;

    localparam logic [19:0] MSR_A = 20'h003F4;
    localparam logic [19:0] DAT_A = 20'h003F5;

    typedef struct packed {
        logic [4:0]  op;
        logic [2:0]  flags;
        logic [63:0] params;
    } exp_cmd_t;

    exp_cmd_t   q_cmd[$];
    logic [7:0] q_rd[$];
    int         total = 0;
    int         bad = 0;

    fdc_cmd_phase dut (
        .clk        (clk),
        .rst        (rst),
        .a          (a),
        .aen        (aen),
        .ior_n      (ior_n),
        .iow_n      (iow_n),
        .din        (din),
        .dout       (dout),
        .dout_en    (dout_en),
        .exec_start (exec_start),
        .cmd_op     (cmd_op),
        .cmd_flags  (cmd_flags),
        .cmd_params (cmd_params),
        .exec_done  (exec_done),
        .res_bytes  (res_bytes),
        .irq6       (irq6)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // exec_start monitor: every pulse must match the oldest queued command
    always @(negedge clk) begin
        if (!rst && exec_start) begin
            if (q_cmd.size() == 0) begin
                chk("exec_start_unexpected", 64'd1, 64'd0);
            end else begin
                exp_cmd_t e;
                e = q_cmd.pop_front();
                chk("cmd_op", 64'(cmd_op), 64'(e.op));
                chk("cmd_flags", 64'(cmd_flags), 64'(e.flags));
                chk("cmd_params", cmd_params, e.params);
            end
        end
    end

    task automatic wr(input logic [19:0] addr, input logic [7:0] data, input int hold);
        @(negedge clk);
        a = addr; din = data; iow_n = 1'b0;
        repeat (hold) @(negedge clk);
        iow_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic rd(input string tag, input logic [19:0] addr, input logic [7:0] exp);
        logic [7:0] e;
        q_rd.push_back(exp);
        @(negedge clk);
        a = addr; ior_n = 1'b0;
        @(negedge clk);
        e = q_rd.pop_front();
        chk(tag, 64'(dout), 64'(e));
        chk({tag, "_en"}, 64'(dout_en), 64'd1);
        ior_n = 1'b1;
        @(negedge clk);
        a = 20'h0;
    endtask

    task automatic done(input logic [55:0] r);
        @(negedge clk);
        res_bytes = r; exec_done = 1'b1;
        @(negedge clk);
        exec_done = 1'b0;
    endtask

    task automatic pulse_rst();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    logic [7:0] rd_cmd [9];
    logic [7:0] rd_res [7];

    initial begin
        rd_cmd = '{8'h06, 8'h01, 8'h00, 8'h00, 8'h01, 8'h02, 8'h09, 8'h2A, 8'hFF};
        rd_res = '{8'h20, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h02};

        repeat (3) @(negedge clk);
        rst = 1'b0;

        // reset state
        rd("msr_reset", MSR_A, 8'h80);
        chk("irq_reset", 64'(irq6), 64'd0);
        @(negedge clk);
        a = MSR_A; aen = 1'b1; ior_n = 1'b0;
        @(negedge clk);
        chk("dout_en_aen", 64'(dout_en), 64'd0);
        ior_n = 1'b1; aen = 1'b0;

        // READ DATA full command/result cycle
        q_cmd.push_back('{op: 5'h06, flags: 3'd0, params: 64'hFF2A090201000001});
        for (int i = 0; i < 9; i++) begin
            wr(DAT_A, rd_cmd[i], 1);
            if (i < 8) rd("msr_cmd", MSR_A, 8'h90);
        end
        rd("msr_exec", MSR_A, 8'h10);
        rd("data_exec", DAT_A, 8'hFF);
        done(56'h02_01_00_00_00_00_20);
        chk("irq_read_set", 64'(irq6), 64'd1);
        rd("msr_result", MSR_A, 8'hD0);
        for (int i = 0; i < 7; i++) begin
            rd("read_res", DAT_A, rd_res[i]);
            if (i == 0) chk("irq_read_clr", 64'(irq6), 64'd0);
        end
        rd("msr_after_read", MSR_A, 8'h80);

        // SEEK, then SENSE INTERRUPT clears irq
        q_cmd.push_back('{op: 5'h0F, flags: 3'd0, params: 64'h0000000000000500});
        wr(DAT_A, 8'h0F, 1);
        wr(DAT_A, 8'h00, 1);
        wr(DAT_A, 8'h05, 1);
        done(56'h0);
        rd("msr_seek_done", MSR_A, 8'h80);
        chk("irq_seek_set", 64'(irq6), 64'd1);
        q_cmd.push_back('{op: 5'h08, flags: 3'd0, params: 64'h0});
        wr(DAT_A, 8'h08, 1);
        chk("irq_sense_clr", 64'(irq6), 64'd0);
        rd("msr_sense_exec", MSR_A, 8'h10);
        done(56'h05_20);
        rd("sense_st0", DAT_A, 8'h20);
        rd("sense_pcn", DAT_A, 8'h05);
        rd("msr_sense_end", MSR_A, 8'h80);

        // Invalid opcode
        wr(DAT_A, 8'h1F, 1);
        rd("msr_invalid", MSR_A, 8'hD0);
        rd("invalid_st0", DAT_A, 8'h80);
        rd("msr_invalid_end", MSR_A, 8'h80);

        // Long strobe counts as one byte; EXEC ignores writes; stray exec_done
        wr(DAT_A, 8'h03, 1);
        wr(DAT_A, 8'hDF, 5);
        rd("msr_long_strobe", MSR_A, 8'h90);
        q_cmd.push_back('{op: 5'h03, flags: 3'd0, params: 64'h00000000000002DF});
        wr(DAT_A, 8'h02, 1);
        wr(DAT_A, 8'h55, 1);
        rd("msr_exec_write", MSR_A, 8'h10);
        done(56'h0);
        rd("msr_specify_end", MSR_A, 8'h80);
        done(56'h01_20);
        rd("msr_done_idle", MSR_A, 8'h80);
        chk("irq_done_idle", 64'(irq6), 64'd0);

        // Reset mid-CMD
        for (int i = 0; i < 4; i++) wr(DAT_A, rd_cmd[i], 1);
        pulse_rst();
        chk("params_rst", cmd_params, 64'd0);
        chk("op_rst", 64'(cmd_op), 64'd0);
        rd("msr_rst_cmd", MSR_A, 8'h80);

        // Reset mid-RESULT with ptr=3
        q_cmd.push_back('{op: 5'h06, flags: 3'd0, params: 64'hFF2A090201000001});
        for (int i = 0; i < 9; i++) wr(DAT_A, rd_cmd[i], 1);
        done(56'h02_01_00_00_00_00_20);
        for (int i = 0; i < 3; i++) rd("read_res_pre_rst", DAT_A, rd_res[i]);
        done(56'h0);
        rd("res_ptr3", DAT_A, rd_res[3]);
        q_rd.delete();
        wr(DAT_A, 8'h00, 1);
        for (int i = 0; i < 0; i++) wr(DAT_A, 8'h00, 1);
        pulse_rst();
        chk("irq_rst_res", 64'(irq6), 64'd0);
        rd("msr_rst_res", MSR_A, 8'h80);
        rd("data_idle", DAT_A, 8'hFF);

        // Fresh SPECIFY after reset
        q_cmd.push_back('{op: 5'h03, flags: 3'd0, params: 64'h00000000000002DF});
        wr(DAT_A, 8'h03, 1);
        wr(DAT_A, 8'hDF, 1);
        wr(DAT_A, 8'h02, 1);
        rd("msr_spec2_exec", MSR_A, 8'h10);
        done(56'h0);
        rd("msr_spec2_end", MSR_A, 8'h80);

        repeat (2) @(negedge clk);
        chk("cmd_queue_empty", 64'(q_cmd.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/fdc_cmd_phase.md
Name: fdc_cmd_phase

Overview:
- Responder end of the host↔FDC register protocol. Decodes ISA I/O cycles to the Main Status Register (0x3F4, read) and the Data Register (0x3F5, read/write).
- Runs the µPD765 command → execution → result phase sequence and drives MSR handshake bits.
- Hands decoded commands to the existing fdc execution logic (SD-card sector engine) and returns its status bytes to the CPU.

Parameters:
- BASE_ADDR, 10'h3F0, I/O base; MSR at BASE+4, data at BASE+5.
- NRES_MAX, 7, maximum result bytes.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- a  in  20  ISA address; only a[9:0] decoded
- aen  in  1  DMA address enable; when 1, no decode
- ior_n  in  1  I/O read strobe, active low
- iow_n  in  1  I/O write strobe, active low
- din  in  8  CPU write data
- dout  out  8  read data (MSR or result byte)
- dout_en  out  1  drive data bus (ior_n=0, aen=0, address hit)
- exec_start  out  1  one-cycle pulse: command ready
- cmd_op  out  5  opcode[4:0] of command
- cmd_flags  out  3  opcode[7:5] (MT, MFM, SK)
- cmd_params  out  64  parameter bytes 1..8, byte1 in [7:0]
- exec_done  in  1  one-cycle pulse from execution engine
- res_bytes  in  56  result bytes 0..6, byte0 (ST0) in [7:0]; sampled on exec_done
- irq6  out  1  interrupt request

Behaviour:
- Write acceptance: iow_n registered; a byte is accepted on the clk after the iow_n 1→0 edge if aen=0 and a[9:0]=BASE+5. Exactly one byte per strobe, regardless of strobe length.
- Read advance: the result pointer advances on the ior_n 0→1 edge when the latched address was BASE+5 and aen=0. MSR reads have no side effect.
- dout is combinational:
  - BASE+4: MSR = {RQM, DIO, NDMA=0, CB, 4'b0}.
  - BASE+5 in RESULT: result byte[ptr].
  - Otherwise 8'hFF.
- Command table (opcode[4:0] → command bytes incl. opcode / result bytes):
  - 06 READ DATA 9/7
  - 05 WRITE DATA 9/7
  - 07 RECALIBRATE 2/0
  - 0F SEEK 3/0
  - 08 SENSE INTERRUPT 1/2
  - 03 SPECIFY 3/0
  - 04 SENSE DRIVE STATUS 2/1
  - other: INVALID 1/1
- States and transitions:
  - IDLE: MSR=0x80. Opcode write → CMD, or → EXEC if the command has 1 byte. INVALID → RESULT with byte0=0x80 and no exec_start.
  - CMD: MSR=0x90. Collect parameters into cmd_params, cleared to 0 on opcode. After the last byte → EXEC.
  - EXEC: MSR=0x10. exec_start pulses on the first cycle only. Data-register writes are ignored; reads return 8'hFF.
    - On exec_done: latch res_bytes.
    - If result count = 0 → IDLE; otherwise → RESULT, ptr=0.
  - RESULT: MSR=0xD0. Each read advances ptr; after reading the last byte → IDLE. Writes in RESULT are ignored.
- irq6:
  - Set on exec_done for READ, WRITE, SEEK, RECALIBRATE.
  - Cleared on the first result-byte read, or on acceptance of a SENSE INTERRUPT opcode.
  - Simultaneous set and clear: set wins.
- exec_done outside EXEC is ignored.
- Reset values (rst=1, any state, including mid-command or mid-result): state IDLE, ptr=0, cmd_params=0, cmd_op=0, cmd_flags=0, latched results=0, exec_start=0, irq6=0, MSR=0x80. Strobe edge registers load 1, so no spurious edge follows reset.
- Widths: parameter counter is 4-bit and saturates at 8; ptr is 3-bit. No wrap-around is possible because transitions occur at the table counts.

Decomposition:
- Shared package fdc_pkg:
  - opcode localparams (OP_READ=5'h06, …)
  - state encoding
  - MSR bit positions
  - per-opcode byte-count function
  - INVALID_ST0=8'h80
- Sub-module fdc_io_decode: address match, aen gating, strobe edge detection (registered ior_n/iow_n, write-accept and read-advance pulses).

Test Plan:
- Reset, read 0x3F4 → dout=0x80, dout_en=1. With aen=1, dout_en=0.
- Write 0x3F5: 06,01,00,00,01,02,09,2A,FF → MSR 0x90 during bytes 1–8. exec_start pulses once; cmd_op=06; cmd_params=64'hFF2A0902010000_01. MSR=0x10 during exec. exec_done with res_bytes=56'h02_01_00_00_00_00_20 → irq6=1, MSR=0xD0. Seven reads return 20,00,00,00,00,01,02; irq6 clears after the first read; MSR=0x80 at end.
- SEEK 0F,00,05 → exec_done → IDLE directly, irq6=1. Then SENSE INTERRUPT 08 → irq6=0. exec_done with res_bytes ST0=0x20, PCN=0x05 → reads 20,05.
- Invalid opcode 0x1F → MSR=0xD0 immediately, single read=0x80, no exec_start, back to 0x80.
- Hold iow_n low 5 cycles with one byte → only one parameter counted. Write during EXEC and exec_done in IDLE → no state change.
- Assert rst mid-CMD (after 4 bytes) and mid-RESULT (ptr=3) → next cycle MSR=0x80, irq6=0. A fresh SPECIFY 03,DF,02 completes normally.
